// File: rtl/alu_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, overflow helpers.
package alu_multiciclo_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_GTU = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_GTS = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DESLOCA    = 2'd1,
        MULTIPLICA = 2'd2
    } estado_t;

    // Signed overflow of a + b, from the operand and result MSBs.
    function automatic logic ovf_soma(input logic a, input logic b, input logic r);
        return (~a & ~b & r) | (a & b & ~r);
    endfunction

    // Signed overflow of a - b, from the operand and result MSBs.
    function automatic logic ovf_sub(input logic a, input logic b, input logic r);
        return (a & ~b & ~r) | (~a & b & r);
    endfunction

endpackage

// File: rtl/alu_multiciclo_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_multiciclo_if #(
    parameter int WIDTH = 16
);
    logic             inicio;
    logic [3:0]       codop;
    logic [WIDTH-1:0] operando1;
    logic [WIDTH-1:0] operando2;
    logic             ocupado;
    logic             pronto;
    logic [WIDTH-1:0] resultado;
    logic             neg;
    logic             zero;
    logic             overflow;
    logic             carry;
    logic             invalido;

    modport master (
        output inicio, codop, operando1, operando2,
        input  ocupado, pronto, resultado, neg, zero, overflow, carry, invalido
    );

    modport slave (
        input  inicio, codop, operando1, operando2,
        output ocupado, pronto, resultado, neg, zero, overflow, carry, invalido
    );
endinterface

// File: rtl/alu_multiciclo_mult_seq.sv
// Sequential shift-add multiplier: WIDTH iterations after start, full 2*WIDTH product.
// done and produto are combinational so the caller can capture the product on the last iteration edge.
module alu_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] produto
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic [2*WIDTH-1:0] acc_next;

    // Partial product for the current multiplier bit.
    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
    end

    assign produto = acc_next;
    assign done    = busy && (cnt == CW'(1));

    // Load on start, then one multiplier bit per clock until the count runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops, iterative shifts, optional shift-add MUL.
//
// state      | meaning
// OCIOSO     | idle; accepts inicio, completes single-cycle ops directly
// DESLOCA    | shifting one bit per clock until the amount is consumed
// MULTIPLICA | waiting for the shift-add multiplier to finish
module alu_multiciclo
    import alu_multiciclo_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_multiciclo_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    estado_t            estado;
    logic [WIDTH-1:0]   a, b;
    logic [WIDTH:0]     soma, dif;
    logic [WIDTH-1:0]   res_uc;
    logic               atualiza_oc, ov_uc, cy_uc, legal, iterativo;
    logic [SHW-1:0]     desloc;

    logic [WIDTH-1:0]   sh_reg, passo;
    logic [SHW-1:0]     sh_cnt;
    logic [3:0]         sh_op;

    logic [WIDTH-1:0]   resultado_r;
    logic               neg_r, zero_r, overflow_r, carry_r, ocupado_r, pronto_r, invalido_r;

    logic               mul_done;
    logic [2*WIDTH-1:0] produto;

    assign a      = bus.operando1;
    assign b      = bus.operando2;
    assign desloc = b[SHW-1:0];

    // Decode the incoming opcode and compute every single-cycle result.
    always_comb begin
        soma        = {1'b0, a} + {1'b0, b};
        dif         = {1'b0, a} - {1'b0, b};
        res_uc      = '0;
        atualiza_oc = 1'b0;
        ov_uc       = 1'b0;
        cy_uc       = 1'b0;
        legal       = 1'b1;
        iterativo   = 1'b0;
        case (bus.codop)
            OP_ADD: begin
                res_uc      = soma[WIDTH-1:0];
                atualiza_oc = 1'b1;
                ov_uc       = ovf_soma(a[WIDTH-1], b[WIDTH-1], soma[WIDTH-1]);
                cy_uc       = soma[WIDTH];
            end
            OP_SUB: begin
                res_uc      = dif[WIDTH-1:0];
                atualiza_oc = 1'b1;
                ov_uc       = ovf_sub(a[WIDTH-1], b[WIDTH-1], dif[WIDTH-1]);
                cy_uc       = dif[WIDTH];
            end
            OP_GTU:  res_uc = WIDTH'(a > b);
            OP_AND:  res_uc = a & b;
            OP_OR:   res_uc = a | b;
            OP_XOR:  res_uc = a ^ b;
            OP_GTS:  res_uc = WIDTH'($signed(a) > $signed(b));
            OP_SLL, OP_SRL, OP_SRA: begin
                res_uc    = a;
                iterativo = (desloc != '0);
            end
            OP_MUL: begin
                legal     = (MUL_EN != 0);
                iterativo = (MUL_EN != 0);
            end
            default: legal = 1'b0;
        endcase
    end

    // One-bit step of the shift in progress; SRA keeps replicating the MSB.
    always_comb begin
        case (sh_op)
            OP_SLL:  passo = sh_reg << 1;
            OP_SRL:  passo = sh_reg >> 1;
            default: passo = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
        endcase
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            logic mul_start;
            assign mul_start = (estado == OCIOSO) && bus.inicio && (bus.codop == OP_MUL);
            alu_mult_seq #(.WIDTH(WIDTH)) u_mult (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .produto (produto)
            );
        end else begin : g_sem_mul
            assign mul_done = 1'b0;
            assign produto  = '0;
        end
    endgenerate

    // Control FSM with registered result, flags and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= OCIOSO;
            sh_reg      <= '0;
            sh_cnt      <= '0;
            sh_op       <= OP_SLL;
            resultado_r <= '0;
            neg_r       <= 1'b0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            carry_r     <= 1'b0;
            ocupado_r   <= 1'b0;
            pronto_r    <= 1'b0;
            invalido_r  <= 1'b0;
        end else begin
            pronto_r   <= 1'b0;
            invalido_r <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (bus.inicio) begin
                        if (!legal) begin
                            resultado_r <= '0;
                            invalido_r  <= 1'b1;
                            pronto_r    <= 1'b1;
                        end else if (!iterativo) begin
                            resultado_r <= res_uc;
                            neg_r       <= res_uc[WIDTH-1];
                            zero_r      <= (res_uc == '0);
                            if (atualiza_oc) begin
                                overflow_r <= ov_uc;
                                carry_r    <= cy_uc;
                            end
                            pronto_r    <= 1'b1;
                        end else if (bus.codop == OP_MUL) begin
                            ocupado_r <= 1'b1;
                            estado    <= MULTIPLICA;
                        end else begin
                            sh_reg    <= a;
                            sh_cnt    <= desloc;
                            sh_op     <= bus.codop;
                            ocupado_r <= 1'b1;
                            estado    <= DESLOCA;
                        end
                    end
                end
                DESLOCA: begin
                    sh_reg <= passo;
                    sh_cnt <= sh_cnt - SHW'(1);
                    if (sh_cnt == SHW'(1)) begin
                        resultado_r <= passo;
                        neg_r       <= passo[WIDTH-1];
                        zero_r      <= (passo == '0);
                        pronto_r    <= 1'b1;
                        ocupado_r   <= 1'b0;
                        estado      <= OCIOSO;
                    end
                end
                MULTIPLICA: begin
                    if (mul_done) begin
                        resultado_r <= produto[WIDTH-1:0];
                        neg_r       <= produto[WIDTH-1];
                        zero_r      <= (produto[WIDTH-1:0] == '0);
                        overflow_r  <= |produto[2*WIDTH-1:WIDTH];
                        carry_r     <= 1'b0;
                        pronto_r    <= 1'b1;
                        ocupado_r   <= 1'b0;
                        estado      <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.resultado = resultado_r;
    assign bus.neg       = neg_r;
    assign bus.zero      = zero_r;
    assign bus.overflow  = overflow_r;
    assign bus.carry     = carry_r;
    assign bus.ocupado   = ocupado_r;
    assign bus.pronto    = pronto_r;
    assign bus.invalido  = invalido_r;
endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo: directed cases plus random ops against an arithmetic reference model.
module tb_alu_multiciclo;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_multiciclo_if #(.WIDTH(W)) bus  ();
    alu_multiciclo_if #(.WIDTH(W)) bus0 ();

    alu_multiciclo #(.WIDTH(W), .MUL_EN(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    alu_multiciclo #(.WIDTH(W), .MUL_EN(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] m_res;
    logic         m_neg, m_zero, m_ov, m_cy;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_chk++;
        if (obs === esp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    endtask

    // Reference: plain integer arithmetic; updates the retained model flags.
    task automatic modelo(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output bit inv);
        int     sa, sb, s, k;
        longint p;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        k   = int'(b[3:0]);
        lat = 0;
        inv = 1'b0;
        case (op)
            4'd0: begin
                s = sa + sb; m_res = a + b;
                m_cy = (int'(a) + int'(b)) > 65535;
                m_ov = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                s = sa - sb; m_res = a - b;
                m_cy = (a < b);
                m_ov = (s > 32767) || (s < -32768);
            end
            4'd2: m_res = (a > b) ? 16'd1 : 16'd0;
            4'd3: m_res = a & b;
            4'd4: m_res = a | b;
            4'd5: m_res = a ^ b;
            4'd6: m_res = (sa > sb) ? 16'd1 : 16'd0;
            4'd7: begin m_res = a << k; lat = k; end
            4'd8: begin m_res = a >> k; lat = k; end
            4'd9: begin m_res = $signed(a) >>> k; lat = k; end
            4'd10: begin
                p = longint'(a) * longint'(b);
                m_res = p[15:0];
                m_ov  = (p >> 16) != 0;
                m_cy  = 1'b0;
                lat   = 16;
            end
            default: begin inv = 1'b1; m_res = '0; end
        endcase
        if (!inv) begin
            m_neg  = m_res[15];
            m_zero = (m_res == 0);
        end
    endtask

    // Issue one op (called #1 after a rising edge) and check result, flags and timing.
    task automatic executa(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit perturba);
        int lat, n;
        bit inv;
        modelo(op, a, b, lat, inv);
        bus.inicio    = 1'b1;
        bus.codop     = op;
        bus.operando1 = a;
        bus.operando2 = b;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        verifica({tag, " ocupado_t0"}, 32'(bus.ocupado), 32'(lat > 0));
        n = 0;
        while (!bus.pronto && n < 100) begin
            if (perturba) begin
                bus.inicio    = 1'b1;
                bus.codop     = 4'($urandom);
                bus.operando1 = 16'($urandom);
                bus.operando2 = 16'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        bus.inicio = 1'b0;
        verifica({tag, " latencia"}, 32'(n), 32'(lat));
        verifica({tag, " resultado"}, 32'(bus.resultado), 32'(m_res));
        verifica({tag, " neg"}, 32'(bus.neg), 32'(m_neg));
        verifica({tag, " zero"}, 32'(bus.zero), 32'(m_zero));
        verifica({tag, " overflow"}, 32'(bus.overflow), 32'(m_ov));
        verifica({tag, " carry"}, 32'(bus.carry), 32'(m_cy));
        verifica({tag, " invalido"}, 32'(bus.invalido), 32'(inv));
        verifica({tag, " ocupado_fim"}, 32'(bus.ocupado), 32'd0);
        @(posedge clk); #1;
        verifica({tag, " pronto_pulso"}, 32'(bus.pronto), 32'd0);
    endtask

    task automatic checa_zerado(input string tag);
        verifica({tag, " resultado"}, 32'(bus.resultado), 32'd0);
        verifica({tag, " flags"}, 32'({bus.neg, bus.zero, bus.overflow, bus.carry}), 32'd0);
        verifica({tag, " handshake"}, 32'({bus.ocupado, bus.pronto, bus.invalido}), 32'd0);
    endtask

    initial begin
        logic [3:0]   op;
        logic [W-1:0] ra, rb;
        bus.inicio = 1'b0; bus.codop = '0; bus.operando1 = '0; bus.operando2 = '0;
        bus0.inicio = 1'b0; bus0.codop = '0; bus0.operando1 = '0; bus0.operando2 = '0;
        m_res = '0; m_neg = 1'b0; m_zero = 1'b0; m_ov = 1'b0; m_cy = 1'b0;

        #2 rst_n = 1'b0;
        #1 checa_zerado("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiplier-less build treats MUL as illegal.
        bus0.inicio = 1'b1; bus0.codop = 4'd10; bus0.operando1 = 16'd7; bus0.operando2 = 16'd6;
        @(posedge clk); #1;
        bus0.inicio = 1'b0;
        verifica("mul_en0 handshake", 32'({bus0.pronto, bus0.invalido, bus0.ocupado}), 32'b110);
        verifica("mul_en0 resultado", 32'(bus0.resultado), 32'd0);
        @(posedge clk); #1;

        executa("add_ovf",  4'd0, 16'h7FFF, 16'h0001, 1'b0);
        executa("sub_neg",  4'd1, 16'h0003, 16'h0005, 1'b0);
        executa("gtu",      4'd2, 16'hFFFF, 16'h0001, 1'b0);
        executa("gts",      4'd6, 16'hFFFF, 16'h0001, 1'b0);
        executa("sra4",     4'd9, 16'h8000, 16'h0004, 1'b0);
        executa("sll0",     4'd7, 16'h0001, 16'h0000, 1'b0);
        executa("srl13",    4'd8, 16'hF0F0, 16'h0013, 1'b0);
        executa("mul7x6",   4'd10, 16'd7, 16'd6, 1'b0);
        executa("mul_ovf",  4'd10, 16'h0100, 16'h0100, 1'b0);
        executa("mul_pert", 4'd10, 16'h1234, 16'h0003, 1'b1);
        executa("sra_pert", 4'd9, 16'h9000, 16'h000F, 1'b1);
        executa("add_ovf2", 4'd0, 16'h8000, 16'h8000, 1'b0);
        executa("ilegal12", 4'd12, 16'h1111, 16'h2222, 1'b0);

        // Reset in the middle of a multiply, then a normal ADD.
        bus.inicio = 1'b1; bus.codop = 4'd10; bus.operando1 = 16'h00FF; bus.operando2 = 16'h00FF;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checa_zerado("reset_mul");
        m_res = '0; m_neg = 1'b0; m_zero = 1'b0; m_ov = 1'b0; m_cy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        executa("add_pos_reset", 4'd0, 16'h0010, 16'h0020, 1'b0);

        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 16'h7FFF + 16'($urandom_range(0, 2));
            executa($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
